// File: rtl/dma_wr_streamer.sv
// dma_wr_streamer: write-side DMA engine. Drains the DMA FIFO read port into
// bus write bursts (address / data / response handshakes).
// Optional build macro: DMA_WR_ERR_ABORT_EN -- when defined, an error response
// ends the transfer after the current burst; otherwise the error is only recorded.

module dma_wr_streamer_chk #(
    parameter int OCC_W = 5
) (
    input logic             clk,
    input logic             rst,
    input logic             fifo_read,
    input logic [OCC_W-1:0] fifo_ocup
);
    // A pop must never be issued against an empty FIFO
    assert property (@(posedge clk) disable iff (rst) fifo_read |-> (fifo_ocup != {OCC_W{1'b0}}));
endmodule

module dma_wr_streamer #(
    parameter int WIDTH     = 32,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 8,
    parameter int SLOTS     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [ADDR_W-1:0]          base_addr_i,
    input  logic [LEN_W-1:0]           num_words_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    input  logic [$clog2(SLOTS):0]     fifo_ocup_i,
    input  logic [WIDTH-1:0]           fifo_data_i,
    output logic                       fifo_read_o,
    output logic                       aw_valid_o,
    input  logic                       aw_ready_i,
    output logic [ADDR_W-1:0]          aw_addr_o,
    output logic [$clog2(MAX_BURST):0] aw_len_o,
    output logic                       w_valid_o,
    input  logic                       w_ready_i,
    output logic [WIDTH-1:0]           w_data_o,
    output logic                       w_last_o,
    input  logic                       b_valid_i,
    output logic                       b_ready_o,
    input  logic                       b_err_i
);
    localparam int BURST_W = $clog2(MAX_BURST) + 1;
    localparam int OCC_W   = $clog2(SLOTS) + 1;
    localparam logic [ADDR_W-1:0] BYTES   = ADDR_W'(WIDTH / 8);
    localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(MAX_BURST);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        ADDR      = 3'd2,
        DATA      = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [ADDR_W-1:0]    addr_r;
    logic [LEN_W-1:0]     remaining_r;
    logic [ADDR_W-1:0]    aw_addr_r;
    logic [BURST_W-1:0]   aw_len_r;
    logic [BURST_W-1:0]   beat_r;
    logic                 err_r;
    logic                 done_r;

    logic [LEN_W-1:0]     burst_s;
    logic                 ocup_ok_s;
    logic [LEN_W-1:0]     burst_len_s;
    logic [LEN_W-1:0]     remaining_next_s;
    logic [ADDR_W-1:0]    burst_bytes_s;
    logic                 last_resp_s;
    logic                 busy_s;
    logic                 aw_valid_s;
    logic                 w_valid_s;
    logic                 b_ready_s;
    logic                 w_last_s;

    // Burst sizing, FIFO occupancy gate and end-of-burst bookkeeping
    always_comb begin
        burst_s          = (remaining_r < MAX_LEN) ? remaining_r : MAX_LEN;
        ocup_ok_s        = (LEN_W'(fifo_ocup_i) >= burst_s);
        burst_len_s      = LEN_W'(aw_len_r) + LEN_W'(1'b1);
        remaining_next_s = remaining_r - burst_len_s;
        burst_bytes_s    = ADDR_W'(burst_len_s) * BYTES;
`ifdef DMA_WR_ERR_ABORT_EN
        last_resp_s      = (remaining_next_s == {LEN_W{1'b0}}) || b_err_i;
`else
        last_resp_s      = (remaining_next_s == {LEN_W{1'b0}});
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a zero-length start never leaves IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i && (num_words_i != {LEN_W{1'b0}})) state_next_s = WAIT_DATA;
                else                                            state_next_s = IDLE;
            end
            WAIT_DATA: begin
                if (ocup_ok_s) state_next_s = ADDR;
                else           state_next_s = WAIT_DATA;
            end
            ADDR: begin
                if (aw_ready_i) state_next_s = DATA;
                else            state_next_s = ADDR;
            end
            DATA: begin
                if (w_ready_i && w_last_s) state_next_s = RESP;
                else                       state_next_s = DATA;
            end
            RESP: begin
                if (b_valid_i) state_next_s = last_resp_s ? IDLE : WAIT_DATA;
                else           state_next_s = RESP;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Handshake strobes decoded from the registered state
    always_comb begin
        busy_s     = 1'b0;
        aw_valid_s = 1'b0;
        w_valid_s  = 1'b0;
        b_ready_s  = 1'b0;
        case (state_r)
            IDLE:      busy_s = 1'b0;
            WAIT_DATA: busy_s = 1'b1;
            ADDR: begin
                busy_s     = 1'b1;
                aw_valid_s = 1'b1;
            end
            DATA: begin
                busy_s    = 1'b1;
                w_valid_s = 1'b1;
            end
            RESP: begin
                busy_s    = 1'b1;
                b_ready_s = 1'b1;
            end
            default: busy_s = 1'b0;
        endcase
        w_last_s = w_valid_s && (beat_r == aw_len_r);
    end

    // Transfer bookkeeping: address, remaining count, burst descriptor, beats, status
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r      <= {ADDR_W{1'b0}};
            remaining_r <= {LEN_W{1'b0}};
            aw_addr_r   <= {ADDR_W{1'b0}};
            aw_len_r    <= {BURST_W{1'b0}};
            beat_r      <= {BURST_W{1'b0}};
            err_r       <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        addr_r      <= base_addr_i;
                        remaining_r <= num_words_i;
                        err_r       <= 1'b0;
                        done_r      <= (num_words_i == {LEN_W{1'b0}});
                    end
                end
                WAIT_DATA: begin
                    if (ocup_ok_s) begin
                        aw_addr_r <= addr_r;
                        aw_len_r  <= BURST_W'(burst_s - LEN_W'(1'b1));
                        beat_r    <= {BURST_W{1'b0}};
                    end
                end
                DATA: begin
                    if (w_ready_i) beat_r <= beat_r + BURST_W'(1'b1);
                end
                RESP: begin
                    if (b_valid_i) begin
                        addr_r      <= addr_r + burst_bytes_s;
                        remaining_r <= last_resp_s ? {LEN_W{1'b0}} : remaining_next_s;
                        err_r       <= err_r | b_err_i;
                        done_r      <= last_resp_s;
                    end
                end
                default: done_r <= 1'b0;
            endcase
        end
    end

    assign busy_o      = busy_s;
    assign done_o      = done_r;
    assign err_o       = err_r;
    assign aw_valid_o  = aw_valid_s;
    assign aw_addr_o   = aw_addr_r;
    assign aw_len_o    = aw_len_r;
    assign w_valid_o   = w_valid_s;
    assign w_data_o    = fifo_data_i;
    assign w_last_o    = w_last_s;
    assign fifo_read_o = w_valid_s & w_ready_i;
    assign b_ready_o   = b_ready_s;

    dma_wr_streamer_chk #(.OCC_W(OCC_W)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .fifo_read (fifo_read_o),
        .fifo_ocup (fifo_ocup_i)
    );
endmodule

// File: tb/tb_dma_wr_streamer.sv
// Directed bench for dma_wr_streamer with a small FIFO model on the read side.
`timescale 1ns/1ps
module tb_dma_wr_streamer;
    localparam int WIDTH     = 32;
    localparam int ADDR_W    = 32;
    localparam int LEN_W     = 16;
    localparam int MAX_BURST = 8;
    localparam int SLOTS     = 16;
    localparam int OCC_W     = $clog2(SLOTS) + 1;
    localparam int BURST_W   = $clog2(MAX_BURST) + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_i;
    logic [ADDR_W-1:0]  base_addr_i;
    logic [LEN_W-1:0]   num_words_i;
    logic               busy_o, done_o, err_o;
    logic [OCC_W-1:0]   fifo_ocup_i;
    logic [WIDTH-1:0]   fifo_data_i;
    logic               fifo_read_o;
    logic               aw_valid_o, aw_ready_i;
    logic [ADDR_W-1:0]  aw_addr_o;
    logic [BURST_W-1:0] aw_len_o;
    logic               w_valid_o, w_ready_i;
    logic [WIDTH-1:0]   w_data_o;
    logic               w_last_o;
    logic               b_valid_i, b_ready_o, b_err_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        fifo_clr = 1'b0;
    logic [31:0] next_val = 32'hA000_0000;
    logic [31:0] exp_val  = 32'hA000_0000;

    dma_wr_streamer #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST), .SLOTS(SLOTS)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
        .num_words_i(num_words_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .fifo_ocup_i(fifo_ocup_i), .fifo_data_i(fifo_data_i), .fifo_read_o(fifo_read_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
        .aw_len_o(aw_len_o), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .w_data_o(w_data_o), .w_last_o(w_last_o), .b_valid_i(b_valid_i),
        .b_ready_o(b_ready_o), .b_err_i(b_err_i)
    );

    always #5 clk = ~clk;

    assign fifo_ocup_i = OCC_W'(wr_ptr - rd_ptr);
    assign fifo_data_i = mem[rd_ptr[7:0]];

    // FIFO model read side: pop on fifo_read_o, or drop everything on clear
    always @(posedge clk) begin
        if (fifo_clr)         rd_ptr <= wr_ptr;
        else if (fifo_read_o) rd_ptr <= rd_ptr + 1;
    end

    // Watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[7:0]] = next_val;
            next_val = next_val + 32'd1;
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic flush();
        @(negedge clk);
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;
        exp_val = next_val;
        #1;
    endtask

    task automatic start_xfer(input logic [31:0] addr, input logic [15:0] n);
        @(negedge clk);
        start_i = 1'b1;
        base_addr_i = addr;
        num_words_i = n;
        @(negedge clk);
        start_i = 1'b0;
        #1;
    endtask

    task automatic wait_aw();
        int cyc;
        cyc = 0;
        while (!aw_valid_o && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("aw_seen", aw_valid_o, 1);
    endtask

    // One complete burst: address check, beats (optionally with backpressure), response
    task automatic do_burst(input logic [31:0] addr, input int n, input logic berr, input logic bp);
        int cyc;
        int k;
        logic [15:0] pat;
        pat = 16'b1011_0010_1110_0110;
        wait_aw();
        chk("aw_addr", aw_addr_o, addr);
        chk("aw_len", aw_len_o, n - 1);
        chk("w_valid_in_addr", w_valid_o, 0);
        @(negedge clk);
        k = 0;
        cyc = 0;
        while (k < n && cyc < 100) begin
            w_ready_i = bp ? pat[cyc[3:0]] : 1'b1;
            #1;
            if (w_ready_i) begin
                chk("w_valid", w_valid_o, 1);
                chk("fifo_read", fifo_read_o, 1);
                chk("w_data", w_data_o, exp_val);
                chk("w_last", w_last_o, (k == n - 1));
                exp_val = exp_val + 32'd1;
                k++;
            end else begin
                chk("stall_valid", w_valid_o, 1);
                chk("stall_no_pop", fifo_read_o, 0);
                chk("stall_data", w_data_o, exp_val);
            end
            @(negedge clk);
            cyc++;
        end
        chk("beat_count", k, n);
        w_ready_i = 1'b0;
        #1;
        chk("b_ready", b_ready_o, 1);
        chk("w_idle_in_resp", w_valid_o, 0);
        b_valid_i = 1'b1;
        b_err_i = berr;
        @(negedge clk);
        b_valid_i = 1'b0;
        b_err_i = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        base_addr_i = 32'h0;
        num_words_i = 16'h0;
        aw_ready_i = 1'b1;
        w_ready_i = 1'b0;
        b_valid_i = 1'b0;
        b_err_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_aw_valid", aw_valid_o, 0);
        chk("rst_w_valid", w_valid_o, 0);
        chk("rst_aw_addr", aw_addr_o, 0);
        chk("rst_aw_len", aw_len_o, 0);
        chk("rst_b_ready", b_ready_o, 0);
        rst = 1'b0;

        // Basic burst: 8 words at 0x1000
        push(8);
        start_xfer(32'h0000_1000, 16'd8);
        chk("t1_busy", busy_o, 1);
        chk("t1_aw_not_yet", aw_valid_o, 0);
        @(negedge clk);
        #1;
        chk("t1_aw_next_cycle", aw_valid_o, 1);
        do_burst(32'h0000_1000, 8, 1'b0, 1'b0);
        chk("t1_done", done_o, 1);
        chk("t1_busy_low", busy_o, 0);
        chk("t1_err", err_o, 0);
        chk("t1_fifo_empty", fifo_ocup_i, 0);
        @(negedge clk);
        #1;
        chk("t1_done_one_cycle", done_o, 0);

        // Multi-burst with FIFO filled 4 words at a time; a start while busy is ignored
        start_xfer(32'h0000_0000, 16'd20);
        push(4);
        start_i = 1'b1;
        base_addr_i = 32'hDEAD_0000;
        num_words_i = 16'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("t2_gate_b1", aw_valid_o, 0);
        push(4);
        do_burst(32'h0000_0000, 8, 1'b0, 1'b0);
        chk("t2_busy_mid", busy_o, 1);
        chk("t2_no_done_mid", done_o, 0);
        push(4);
        repeat (3) @(negedge clk);
        #1;
        chk("t2_gate_b2", aw_valid_o, 0);
        push(4);
        do_burst(32'h0000_0020, 8, 1'b0, 1'b0);
        push(4);
        do_burst(32'h0000_0040, 4, 1'b0, 1'b0);
        chk("t2_done", done_o, 1);
        chk("t2_busy_low", busy_o, 0);

        // Backpressure on both address and data channels
        push(8);
        aw_ready_i = 1'b0;
        start_xfer(32'h0000_2000, 16'd8);
        wait_aw();
        repeat (2) @(negedge clk);
        #1;
        chk("t3_aw_held", aw_valid_o, 1);
        chk("t3_aw_addr_held", aw_addr_o, 32'h0000_2000);
        aw_ready_i = 1'b1;
        do_burst(32'h0000_2000, 8, 1'b0, 1'b1);
        chk("t3_done", done_o, 1);

        // Zero length
        start_xfer(32'h0000_3000, 16'd0);
        chk("t4_zero_done", done_o, 1);
        chk("t4_zero_busy", busy_o, 0);
        chk("t4_zero_aw", aw_valid_o, 0);
        @(negedge clk);
        #1;
        chk("t4_zero_done_clear", done_o, 0);
        chk("t4_zero_aw2", aw_valid_o, 0);

        // Address wrap: second burst lands at 0x8
        push(12);
        start_xfer(32'hFFFF_FFE8, 16'd12);
        do_burst(32'hFFFF_FFE8, 8, 1'b0, 1'b0);
        do_burst(32'h0000_0008, 4, 1'b0, 1'b0);
        chk("t4_wrap_done", done_o, 1);

        // Error response on the first of two bursts
        push(16);
        start_xfer(32'h0000_4000, 16'd16);
        do_burst(32'h0000_4000, 8, 1'b1, 1'b0);
`ifdef DMA_WR_ERR_ABORT_EN
        chk("t5_abort_done", done_o, 1);
        chk("t5_abort_err", err_o, 1);
        chk("t5_abort_busy", busy_o, 0);
        chk("t5_abort_left", fifo_ocup_i, 8);
        flush();
`else
        chk("t5_err_sticky", err_o, 1);
        chk("t5_busy_mid", busy_o, 1);
        do_burst(32'h0000_4020, 8, 1'b0, 1'b0);
        chk("t5_done", done_o, 1);
        chk("t5_err_final", err_o, 1);
`endif
        start_xfer(32'h0000_5000, 16'd0);
        chk("t5_err_cleared", err_o, 0);
        chk("t5_zero_done", done_o, 1);

        // Reset in the middle of the data phase
        push(8);
        start_xfer(32'h0000_6000, 16'd8);
        wait_aw();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            w_ready_i = 1'b1;
            #1;
            chk("t6_pre_data", w_data_o, exp_val);
            exp_val = exp_val + 32'd1;
            @(negedge clk);
        end
        w_ready_i = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("t6_busy", busy_o, 0);
        chk("t6_done", done_o, 0);
        chk("t6_err", err_o, 0);
        chk("t6_fifo_read", fifo_read_o, 0);
        chk("t6_aw_valid", aw_valid_o, 0);
        chk("t6_w_valid", w_valid_o, 0);
        chk("t6_w_last", w_last_o, 0);
        chk("t6_b_ready", b_ready_o, 0);
        chk("t6_aw_addr", aw_addr_o, 0);
        chk("t6_aw_len", aw_len_o, 0);
        rst = 1'b0;
        w_ready_i = 1'b0;
        flush();
        push(4);
        start_xfer(32'h0000_7000, 16'd4);
        chk("t6_restart_busy", busy_o, 1);
        do_burst(32'h0000_7000, 4, 1'b0, 1'b0);
        chk("t6_restart_done", done_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
